ctrl_pipe: RTL and testbench

Pipelined, hazard-aware successor to the single-cycle control decoder. It decodes the ID-stage opcode into the nine datapath control bits and registers them through the ID/EX, EX/MEM and MEM/WB boundaries, so each stage receives its own bits. It detects load-use hazards and stalls the front end, and it flushes wrong-path instructions on a taken branch. It sits between the IF/ID register and the datapath pipeline registers of the 5-stage core.

---
 rtl/ctrl_pkg.sv | 49 ++++
 rtl/ctrl_dec.sv | 25 ++
 rtl/ctrl_pipe.sv | 131 +++++++++++++
 tb/tb_ctrl_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, per-stage control structs and source-usage helpers
// for the pipelined control unit.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b101100;
    localparam logic [5:0] OP_LOAD  = 6'b100011;
    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_BNZ   = 6'b000111;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    typedef struct packed {
        logic regwr;
        logic memreg;
        logic br;
        logic memwr;
        logic memrd;
        logic aluop1;
        logic aluop2;
        logic alusrc;
        logic regdst;
    } ctrl_t;

    typedef struct packed {
        logic regwr;
        logic memreg;
        logic br;
        logic memwr;
        logic memrd;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwr;
        logic memreg;
    } wb_ctrl_t;

    // NOP control pattern: only aluop2 set
    localparam ctrl_t BUBBLE = ctrl_t'(9'b000000100);

    function automatic logic rs_used(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BNZ);
    endfunction

    function automatic logic rt_used(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Combinational opcode decoder: opcode -> nine control bits, plus a flag for
// opcodes outside the defined set (which decode as NOP).
module ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    always_comb begin
        ctrl_o    = BUBBLE;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: ctrl_o = ctrl_t'(9'b100000101);
            OP_ADDI:  ctrl_o = ctrl_t'(9'b100001110);
            OP_LOAD:  ctrl_o = ctrl_t'(9'b110010010);
            OP_STORE: ctrl_o = ctrl_t'(9'b000100010);
            OP_BNZ:   ctrl_o = ctrl_t'(9'b001001000);
            OP_NOP:   ctrl_o = BUBBLE;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes ID, carries controls through ID/EX, EX/MEM,
// MEM/WB, stalls on load-use and flushes on taken branch. Optional ILLEGAL_CNT_EN.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int RAW        = 5,
    parameter int BR_RESOLVE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [5:0]     id_op,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] ex_wreg,
    input  logic           br_taken,
    output logic           stall_o,
    output logic           ex_valid,
    output logic           ex_aluop1,
    output logic           ex_aluop2,
    output logic           ex_alusrc,
    output logic           ex_regdst,
    output logic           mem_valid,
    output logic           mem_br,
    output logic           mem_memwr,
    output logic           mem_memrd,
    output logic           wb_valid,
    output logic           wb_regwr,
`ifdef ILLEGAL_CNT_EN
    output logic           wb_memreg,
    output logic [15:0]    illegal_cnt
`else
    output logic           wb_memreg
`endif
);

    ctrl_t     dec_ctrl;
    logic      dec_illegal;
    logic      hz;

    ctrl_t     ex_ctrl_q,  ex_ctrl_d;
    logic      ex_vld_q,   ex_vld_d;
    mem_ctrl_t mem_ctrl_q, mem_ctrl_d;
    logic      mem_vld_q,  mem_vld_d;
    wb_ctrl_t  wb_ctrl_q,  wb_ctrl_d;
    logic      wb_vld_q,   wb_vld_d;

    ctrl_dec u_dec (
        .op_i      (id_op),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // Undecoded opcodes read no sources, so they never trigger a load-use stall
    always_comb begin
        hz = ex_vld_q & ex_ctrl_q.memrd & (ex_wreg != '0) & id_valid & ~dec_illegal &
             ((rs_used(id_op) & (id_rs == ex_wreg)) |
              (rt_used(id_op) & (id_rt == ex_wreg)));
        stall_o = hz & ~br_taken;
    end

    always_comb begin
        // ID -> EX
        ex_ctrl_d = dec_ctrl;
        ex_vld_d  = 1'b1;
        if (br_taken || stall_o || !id_valid) begin
            ex_ctrl_d = BUBBLE;
            ex_vld_d  = 1'b0;
        end
        // EX -> MEM
        mem_ctrl_d = '{regwr: ex_ctrl_q.regwr, memreg: ex_ctrl_q.memreg, br: ex_ctrl_q.br,
                       memwr: ex_ctrl_q.memwr, memrd: ex_ctrl_q.memrd};
        mem_vld_d  = ex_vld_q;
        if (BR_RESOLVE == 2 && br_taken) begin
            mem_ctrl_d = '0;
            mem_vld_d  = 1'b0;
        end
        // MEM -> WB always advances
        wb_ctrl_d = '{regwr: mem_ctrl_q.regwr, memreg: mem_ctrl_q.memreg};
        wb_vld_d  = mem_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q  <= BUBBLE;
            ex_vld_q   <= 1'b0;
            mem_ctrl_q <= '0;
            mem_vld_q  <= 1'b0;
            wb_ctrl_q  <= '0;
            wb_vld_q   <= 1'b0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_vld_q   <= ex_vld_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_vld_q  <= mem_vld_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_vld_q   <= wb_vld_d;
        end
    end

`ifdef ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (id_valid && !stall_o && !br_taken && dec_illegal && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign illegal_cnt = cnt_q;
`endif

    assign ex_valid  = ex_vld_q;
    assign ex_aluop1 = ex_ctrl_q.aluop1;
    assign ex_aluop2 = ex_ctrl_q.aluop2;
    assign ex_alusrc = ex_ctrl_q.alusrc;
    assign ex_regdst = ex_ctrl_q.regdst;
    assign mem_valid = mem_vld_q;
    assign mem_br    = mem_ctrl_q.br;
    assign mem_memwr = mem_ctrl_q.memwr;
    assign mem_memrd = mem_ctrl_q.memrd;
    assign wb_valid  = wb_vld_q;
    assign wb_regwr  = wb_ctrl_q.regwr;
    assign wb_memreg = wb_ctrl_q.memreg;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (BR_RESOLVE = 2): decode latency, load-use stall,
// branch flush, reset; illegal counter when ILLEGAL_CNT_EN is defined.
module tb_ctrl_pipe;

    localparam int RAW = 5;
    localparam logic [5:0] RT = 6'b000001, ADDI = 6'b101100, LD = 6'b100011,
                           ST = 6'b101011, BNZ = 6'b000111, ILL = 6'b010101;

    logic           clk = 1'b0;
    logic           rst;
    logic           id_valid;
    logic [5:0]     id_op;
    logic [RAW-1:0] id_rs, id_rt, ex_wreg;
    logic           br_taken;
    logic           stall_o;
    logic           ex_valid, ex_aluop1, ex_aluop2, ex_alusrc, ex_regdst;
    logic           mem_valid, mem_br, mem_memwr, mem_memrd;
    logic           wb_valid, wb_regwr, wb_memreg;
`ifdef ILLEGAL_CNT_EN
    logic [15:0]    illegal_cnt;
`endif

    int n_chk = 0;
    int n_bad = 0;

    ctrl_pipe #(.RAW(RAW), .BR_RESOLVE(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .ex_wreg(ex_wreg), .br_taken(br_taken),
        .stall_o(stall_o), .ex_valid(ex_valid), .ex_aluop1(ex_aluop1),
        .ex_aluop2(ex_aluop2), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
        .mem_valid(mem_valid), .mem_br(mem_br), .mem_memwr(mem_memwr),
        .mem_memrd(mem_memrd), .wb_valid(wb_valid), .wb_regwr(wb_regwr),
`ifdef ILLEGAL_CNT_EN
        .wb_memreg(wb_memreg), .illegal_cnt(illegal_cnt)
`else
        .wb_memreg(wb_memreg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [RAW-1:0] rs,
                         input logic [RAW-1:0] rt, input logic [RAW-1:0] wr, input logic br);
        id_valid = v; id_op = op; id_rs = rs; id_rt = rt; ex_wreg = wr; br_taken = br;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 6'h3f, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_ex_valid",  ex_valid, 0);
        chk("rst_ex_aluop2", ex_aluop2, 1);
        chk("rst_ex_aluop1", ex_aluop1, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid",  wb_valid, 0);
        chk("rst_wb_regwr",  wb_regwr, 0);
        chk("rst_stall",     stall_o, 0);
`ifdef ILLEGAL_CNT_EN
        chk("rst_illcnt", illegal_cnt, 0);
`endif

        // ADDI stream
        rst = 1'b0;
        drive(1, ADDI, 1, 2, 0, 0);
        tick();
        chk("addi_ex_valid",  ex_valid, 1);
        chk("addi_ex_aluop1", ex_aluop1, 1);
        chk("addi_ex_aluop2", ex_aluop2, 1);
        chk("addi_ex_alusrc", ex_alusrc, 1);
        chk("addi_ex_regdst", ex_regdst, 0);
        tick();
        chk("addi_mem_valid", mem_valid, 1);
        tick();
        chk("addi_wb_valid",  wb_valid, 1);
        chk("addi_wb_regwr",  wb_regwr, 1);
        chk("addi_wb_memreg", wb_memreg, 0);

        // load-use on rt
        drive(1, LD, 1, 2, 0, 0);
        tick();
        drive(1, RT, 4, 3, 3, 0);
        chk("lu_stall", stall_o, 1);
        tick();
        chk("lu_ex_bubble", ex_valid, 0);
        chk("lu_mem_memrd", mem_memrd, 1);
        chk("lu_stall_drop", stall_o, 0);
        tick();
        chk("lu_rt_ex_valid",  ex_valid, 1);
        chk("lu_rt_ex_regdst", ex_regdst, 1);
        chk("lu_rt_ex_alusrc", ex_alusrc, 0);
        chk("lu_ld_wb_memreg", wb_memreg, 1);

        // non-hazard and other hazard variants with a LOAD in EX
        drive(1, LD, 1, 2, 0, 0);
        tick();
        drive(1, RT, 0, 0, 0, 0);
        chk("nohz_wreg0", stall_o, 0);
        drive(1, ADDI, 1, 3, 3, 0);
        chk("nohz_addi_rt", stall_o, 0);
        drive(1, ADDI, 3, 1, 3, 0);
        chk("hz_addi_rs", stall_o, 1);
        drive(1, ST, 1, 3, 3, 0);
        chk("hz_store_rt", stall_o, 1);

        // branch in MEM flushes EX and MEM
        drive(1, BNZ, 0, 0, 0, 0);
        tick();
        drive(1, RT, 1, 2, 0, 0);
        tick();
        chk("br_mem_br",    mem_br, 1);
        chk("br_mem_valid", mem_valid, 1);
        drive(1, ADDI, 1, 2, 0, 1);
        tick();
        chk("fl_ex_valid",  ex_valid, 0);
        chk("fl_ex_aluop2", ex_aluop2, 1);
        chk("fl_mem_valid", mem_valid, 0);
        chk("fl_mem_br",    mem_br, 0);
        chk("fl_wb_valid",  wb_valid, 1);
        chk("fl_wb_regwr",  wb_regwr, 0);

        // branch beats load-use
        drive(1, LD, 1, 2, 0, 0);
        tick();
        drive(1, RT, 4, 3, 3, 1);
        chk("brhz_stall", stall_o, 0);
        tick();
        chk("brhz_ex_valid",  ex_valid, 0);
        chk("brhz_mem_valid", mem_valid, 0);

        // invalid ID
        drive(0, ADDI, 1, 2, 0, 0);
        tick();
        chk("inv_ex_valid",  ex_valid, 0);
        chk("inv_ex_aluop1", ex_aluop1, 0);

        // undecoded opcode decodes as NOP
        drive(1, ILL, 1, 2, 0, 0);
        tick(); tick(); tick();
        chk("ill_ex_valid",  ex_valid, 1);
        chk("ill_ex_aluop2", ex_aluop2, 1);
        chk("ill_ex_aluop1", ex_aluop1, 0);
        chk("ill_ex_alusrc", ex_alusrc, 0);
        chk("ill_ex_regdst", ex_regdst, 0);
        chk("ill_wb_regwr",  wb_regwr, 0);
`ifdef ILLEGAL_CNT_EN
        chk("ill_cnt", illegal_cnt, 3);
`endif

        // reset mid-pipeline during a stall
        drive(1, LD, 1, 2, 0, 0);
        tick();
        drive(1, RT, 4, 3, 3, 0);
        chk("mr_stall_pre", stall_o, 1);
        rst = 1'b1;
        tick();
        chk("mr_ex_valid",  ex_valid, 0);
        chk("mr_ex_aluop2", ex_aluop2, 1);
        chk("mr_mem_valid", mem_valid, 0);
        chk("mr_mem_memrd", mem_memrd, 0);
        chk("mr_wb_valid",  wb_valid, 0);
        chk("mr_stall",     stall_o, 0);
`ifdef ILLEGAL_CNT_EN
        chk("mr_illcnt", illegal_cnt, 0);
`endif
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
